// File: rtl/define_state.sv
// define_state: shared arbiter states, requester indices and parameter defaults
package define_state;
    typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_GRANT, S_ARB_TURN} sram_arb_state_type;
    localparam logic [1:0] ARB_UART = 2'd0;
    localparam logic [1:0] ARB_DEC  = 2'd1;
    localparam logic [1:0] ARB_VGA  = 2'd2;
    localparam int DEFAULT_MAX_BURST    = 256;
    localparam int DEFAULT_READ_LATENCY = 2;
endpackage

// File: rtl/arb_priority_select.sv
// arb_priority_select: masked fixed-priority one-hot selector, VGA > UART > decoder
module arb_priority_select
    import define_state::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    output logic [2:0] sel,
    output logic [1:0] idx,
    output logic       any
);
    logic [2:0] m;
    assign m   = req & ~mask;
    assign any = |m;
    assign idx = m[ARB_VGA] ? ARB_VGA : m[ARB_UART] ? ARB_UART : ARB_DEC;
    assign sel = any ? 3'b001 << idx : 3'b000;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-requester SRAM port arbiter with burst preemption and read-valid pipeline
module sram_arbiter
    import define_state::*;
#(
    parameter int MAX_BURST    = DEFAULT_MAX_BURST,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
)(
    input  logic             CLOCK_50_I,
    input  logic             resetn,
    input  logic             SRAM_ready,
    input  logic [2:0]       req_i,
    input  logic [2:0][17:0] addr_i,
    input  logic [2:0]       we_n_i,
    input  logic [2:0][15:0] wdata_i,
    output logic [2:0]       gnt_o,
    output logic [2:0]       rd_valid_o,
    output logic [17:0]      SRAM_address,
    output logic [15:0]      SRAM_write_data,
    output logic             SRAM_we_n,
    output logic [1:0]       owner_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    sram_arb_state_type state, next_state;
    logic [1:0] owner, next_owner, sel_idx;
    logic [2:0] next_gnt, mask, next_mask, sel;
    logic [CW-1:0] cnt, next_cnt;
    logic [2:0][READ_LATENCY-1:0] rd_sr;
    logic sel_any, own_req, active;

    arb_priority_select u_sel (.req(req_i), .mask(mask), .sel(sel), .idx(sel_idx), .any(sel_any));

    // gnt_o is one-hot on the owner while granted, so it doubles as the owner's request tap
    assign own_req         = |(req_i & gnt_o);
    assign active          = (state == S_ARB_GRANT) && own_req;
    assign SRAM_address    = active ? addr_i[owner] : '0;
    assign SRAM_write_data = active ? wdata_i[owner] : '0;
    assign SRAM_we_n       = active ? we_n_i[owner] : 1'b1;
    assign owner_o         = (state == S_ARB_GRANT) ? owner : 2'd3;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state <= S_ARB_IDLE;
            owner <= ARB_UART;
            gnt_o <= '0;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= next_state;
            owner <= next_owner;
            gnt_o <= next_gnt;
            cnt   <= next_cnt;
            mask  <= next_mask;
        end
    end

    always_comb begin
        next_state = state;
        next_owner = owner;
        next_gnt   = gnt_o;
        next_cnt   = cnt;
        next_mask  = mask;
        if (!SRAM_ready) begin
            next_state = S_ARB_IDLE;
            next_gnt   = '0;
            next_mask  = '0;
        end else begin
            unique case (state)
                S_ARB_IDLE: begin
                    // the mask only ever applies to one arbitration attempt
                    next_mask = '0;
                    if (sel_any) begin
                        next_state = S_ARB_GRANT;
                        next_owner = sel_idx;
                        next_gnt   = sel;
                        next_cnt   = '0;
                    end
                end
                S_ARB_GRANT: begin
                    next_cnt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    if (!own_req) begin
                        next_state = S_ARB_TURN;
                        next_gnt   = '0;
                    end else if (cnt == CNT_MAX && |(req_i & ~gnt_o)) begin
                        next_state = S_ARB_TURN;
                        next_gnt   = '0;
                        next_mask  = gnt_o;
                    end
                end
                S_ARB_TURN: next_state = S_ARB_IDLE;
                default:    next_state = S_ARB_IDLE;
            endcase
        end
    end

    // read strobes keep shifting regardless of grant or SRAM_ready
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)
            rd_sr <= '0;
        else
            for (int k = 0; k < 3; k++)
                rd_sr[k] <= (rd_sr[k] << 1) | READ_LATENCY'(gnt_o[k] & req_i[k] & we_n_i[k]);
    end

    for (genvar k = 0; k < 3; k++) begin : g_rd
        assign rd_valid_o[k] = rd_sr[k][READ_LATENCY-1];
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed scoreboard bench for sram_arbiter
module tb_sram_arbiter;
    localparam int MB = 256;
    localparam int RL = 2;

    logic clk = 0, rstn = 0, ready = 1;
    logic [2:0] req = '0, we_n = 3'b111;
    logic [2:0][17:0] addr = '0;
    logic [2:0][15:0] wdata = '0;
    logic [2:0] gnt_o, rd_valid_o;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic SRAM_we_n;
    logic [1:0] owner_o;

    sram_arbiter #(.MAX_BURST(MB), .READ_LATENCY(RL)) dut (
        .CLOCK_50_I(clk), .resetn(rstn), .SRAM_ready(ready), .req_i(req),
        .addr_i(addr), .we_n_i(we_n), .wdata_i(wdata), .gnt_o(gnt_o),
        .rd_valid_o(rd_valid_o), .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .owner_o(owner_o)
    );

    always #10 clk = ~clk;

    typedef struct {int k; int due;} rd_exp_t;
    rd_exp_t q[$];
    int holder = -1, held = 0, skip = -1, cyc = 0, turn = 0;
    int checks = 0, failures = 0, rv1_count = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: who holds the port, how long, whether a turnaround or skip is pending
    task automatic model_step();
        int pick;
        if (!rstn) begin
            holder = -1; held = 0; skip = -1; turn = 0;
            q.delete();
            return;
        end
        if (holder >= 0 && req[holder] && we_n[holder]) q.push_back('{holder, cyc + RL});
        if (!ready) begin
            holder = -1; turn = 0; skip = -1;
        end else if (holder >= 0) begin
            if (!req[holder]) begin
                holder = -1; turn = 1;
            end else if (held >= MB - 1 && (req & ~(3'b001 << holder)) != 0) begin
                skip = holder; holder = -1; turn = 1;
            end else held++;
        end else if (turn != 0) begin
            turn = 0;
        end else begin
            pick = -1;
            if (req[2] && skip != 2) pick = 2;
            else if (req[0] && skip != 0) pick = 0;
            else if (req[1] && skip != 1) pick = 1;
            skip = -1;
            if (pick >= 0) begin holder = pick; held = 0; end
        end
        cyc++;
    endtask

    task automatic monitor();
        logic [2:0] exp_rv;
        if (holder >= 0) begin
            check("gnt_o", gnt_o, 1 << holder);
            check("owner_o", owner_o, holder);
        end else begin
            check("gnt_o", gnt_o, 0);
            check("owner_o", owner_o, 3);
        end
        if (holder >= 0 && req[holder]) begin
            check("SRAM_address", SRAM_address, addr[holder]);
            check("SRAM_write_data", SRAM_write_data, wdata[holder]);
            check("SRAM_we_n", SRAM_we_n, we_n[holder]);
        end else begin
            check("SRAM_address", SRAM_address, 0);
            check("SRAM_write_data", SRAM_write_data, 0);
            check("SRAM_we_n", SRAM_we_n, 1);
        end
        exp_rv = '0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            if (q[0].due == cyc) exp_rv[q[0].k] = 1'b1;
            void'(q.pop_front());
        end
        if (rd_valid_o != 0 || exp_rv != 0) check("rd_valid_o", rd_valid_o, exp_rv);
        if (rd_valid_o[1]) rv1_count++;
    endtask

    always @(posedge clk or negedge rstn) model_step();
    always @(negedge clk) monitor();

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int run, done, base;
        step(3);
        rstn = 1;
        step(2);
        addr[0] = 18'h00010; wdata[0] = 16'hABCD; we_n[0] = 1'b0; req = 3'b001;
        step(1);
        check("uart_grant_latency", gnt_o, 3'b001);
        check("uart_write_addr", SRAM_address, 18'h00010);
        check("uart_write_we_n", SRAM_we_n, 0);
        step(2);
        req = 3'b000; we_n[0] = 1'b1;
        step(1);
        check("uart_turn_gnt", gnt_o, 0);
        check("uart_turn_owner", owner_o, 3);
        step(3);
        base = rv1_count;
        we_n[1] = 1'b1; addr[1] = 18'h00100; req = 3'b010;
        step(1);
        for (int i = 0; i < 4; i++) begin
            addr[1] = 18'h00100 + 18'(i);
            step(1);
        end
        req = 3'b000;
        step(5);
        check("dec_read_pulses", rv1_count - base, 4);
        req = 3'b111;
        step(1);
        check("all_rise_vga", gnt_o, 3'b100);
        req = 3'b011;
        step(3);
        check("after_vga_uart", gnt_o, 3'b001);
        req = 3'b000;
        step(3);
        req = 3'b110; run = 0; done = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (gnt_o == 3'b100 && done == 0) run++;
            else if (run > 0) done = 1;
        end
        check("vga_burst_len", run, MB);
        check("dec_after_preempt", gnt_o, 3'b010);
        req = 3'b100;
        step(3);
        check("vga_regrant", gnt_o, 3'b100);
        req = 3'b000;
        step(3);
        we_n[1] = 1'b1; req = 3'b010;
        step(3);
        ready = 1'b0;
        step(1);
        check("ready_drop_gnt", gnt_o, 0);
        step(3);
        check("no_regrant_not_ready", gnt_o, 0);
        ready = 1'b1;
        step(1);
        check("regrant_after_ready", gnt_o, 3'b010);
        req = 3'b000;
        step(4);
        req = 3'b010;
        step(3);
        rstn = 1'b0;
        #1;
        base = rv1_count;
        check("reset_gnt", gnt_o, 0);
        check("reset_owner", owner_o, 3);
        check("reset_rd_valid", rd_valid_o, 0);
        check("reset_we_n", SRAM_we_n, 1);
        check("reset_addr", SRAM_address, 0);
        req = 3'b000;
        step(2);
        rstn = 1'b1;
        step(6);
        check("no_stray_rd_valid", rv1_count - base, 0);
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (req[k]) begin
                    if ($urandom_range(0, 7) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) req[k] = 1'b1;
                we_n[k]  = 1'($urandom_range(0, 1));
                addr[k]  = 18'($urandom);
                wdata[k] = 16'($urandom);
            end
            ready = $urandom_range(0, 39) != 0;
            rstn  = $urandom_range(0, 799) != 0;
            step(1);
        end
        rstn = 1'b1; req = 3'b000;
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
